// File: rtl/ddr3_dq_sched.sv
// DDR3 DQ bus scheduler: grants read/write bursts, inserts direction turnaround and
// emits registered delay-line markers. Optional macro DDR3_DQ_SCHED_STARVE_EN caps same-direction runs.
module ddr3_dq_sched #(
    parameter int BL_CYC  = 2,
    parameter int TURN    = 2,
    parameter int MAX_RUN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rd_req,
    input  logic       wr_req,
    output logic       rd_gnt,
    output logic       wr_gnt,
    output logic [3:0] sr_in,
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;

    localparam logic [3:0] BL_LAST    = 4'(BL_CYC - 1);
    localparam logic [3:0] TURN_LOAD  = 4'(TURN);
    localparam logic [3:0] TURN_LAST  = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    if (BL_CYC < 1 || BL_CYC > 15 || TURN < 0 || TURN > 15 || MAX_RUN < 1 || MAX_RUN > 255) begin : g_bad_param
        $error("ddr3_dq_sched: parameter out of legal range");
    end

    state_t     state_q, state_d;
    logic [3:0] bcnt_q, bcnt_d;
    logic [3:0] tcnt_q, tcnt_d;
    logic       last_wr_q, last_wr_d;
    logic       rd_gnt_q, wr_gnt_q;
    logic [3:0] sr_q, sr_d;

    logic       grant_rd, grant_wr;
    logic       cur_wr, same_req, opp_req, stay, opp_ok, pend_req;

`ifdef DDR3_DQ_SCHED_STARVE_EN
    localparam logic [7:0] RUN_CAP = 8'(MAX_RUN);
    logic [7:0] run_q, run_d;
`endif

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        tcnt_d    = tcnt_q;
        last_wr_d = last_wr_q;
        grant_rd  = 1'b0;
        grant_wr  = 1'b0;
        cur_wr    = (state_q == S_WR);
        same_req  = cur_wr ? wr_req : rd_req;
        opp_req   = cur_wr ? rd_req : wr_req;
        stay      = same_req;
        opp_ok    = (tcnt_q <= 4'd1);
        pend_req  = last_wr_q ? rd_req : wr_req;
        sr_d      = 4'b0000;
`ifdef DDR3_DQ_SCHED_STARVE_EN
        run_d     = run_q;
        if (run_q >= RUN_CAP && opp_req) stay = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                // tcnt holds the turnaround still owed by the burst that ended into IDLE
                if (tcnt_q != 4'd0) tcnt_d = tcnt_q - 4'd1;
                if (rd_req && wr_req) begin
                    if (opp_ok) begin
                        grant_rd = last_wr_q;
                        grant_wr = !last_wr_q;
                    end
                end else if (rd_req) begin
                    grant_rd = !last_wr_q || opp_ok;
                end else if (wr_req) begin
                    grant_wr = last_wr_q || opp_ok;
                end
            end
            S_RD, S_WR: begin
                bcnt_d = bcnt_q + 4'd1;
                if (bcnt_q == BL_LAST) begin
                    if (stay) begin
                        grant_wr = cur_wr;
                        grant_rd = !cur_wr;
                    end else if (opp_req) begin
                        if (TURN == 0) begin
                            grant_wr = !cur_wr;
                            grant_rd = cur_wr;
                        end else begin
                            state_d = S_TURN;
                            tcnt_d  = TURN_LAST;
                        end
                    end else begin
                        state_d = S_IDLE;
                        tcnt_d  = TURN_LOAD;
                    end
                end
            end
            S_TURN: begin
                if (tcnt_q != 4'd0) begin
                    tcnt_d = tcnt_q - 4'd1;
                end else if (pend_req) begin
                    grant_rd = last_wr_q;
                    grant_wr = !last_wr_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (grant_rd || grant_wr) begin
            state_d   = grant_wr ? S_WR : S_RD;
            bcnt_d    = 4'd0;
            tcnt_d    = 4'd0;
            last_wr_d = grant_wr;
`ifdef DDR3_DQ_SCHED_STARVE_EN
            if (grant_wr == last_wr_q) run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
            else                       run_d = 8'd1;
`endif
        end

        // Markers are computed from the next state so they line up with the burst cycle
        if (state_d == S_RD)      sr_d = {1'b0, bcnt_d == BL_LAST, 1'b0, 1'b1};
        else if (state_d == S_WR) sr_d = {bcnt_d == BL_LAST, 1'b0, 1'b1, 1'b0};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bcnt_q    <= 4'd0;
            tcnt_q    <= 4'd0;
            last_wr_q <= 1'b1;
            rd_gnt_q  <= 1'b0;
            wr_gnt_q  <= 1'b0;
            sr_q      <= 4'b0000;
`ifdef DDR3_DQ_SCHED_STARVE_EN
            run_q     <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            bcnt_q    <= bcnt_d;
            tcnt_q    <= tcnt_d;
            last_wr_q <= last_wr_d;
            rd_gnt_q  <= grant_rd;
            wr_gnt_q  <= grant_wr;
            sr_q      <= sr_d;
`ifdef DDR3_DQ_SCHED_STARVE_EN
            run_q     <= run_d;
`endif
        end
    end

    assign rd_gnt = rd_gnt_q;
    assign wr_gnt = wr_gnt_q;
    assign sr_in  = sr_q;
    assign busy   = (state_q != S_IDLE);

endmodule
